// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: instruction-fetch PC sequencer.
// Picks the next fetch PC from the EX-stage redirects (JALR, taken branch), the
// ID-stage JAL redirect, or the sequential PC+4. A redirect that arrives while
// fetch is stalled is parked in a one-entry pending register and applied when
// the stall releases. clear_d tells the IF-ID register to squash its slot
// whenever fetch leaves the sequential path, and during the boot cycle.
// RESET_PC must be word aligned (bits [1:0] zero).
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_f,
    input  logic        jalr_e,
    input  logic [31:0] jalr_target_e,
    input  logic        br_e,
    input  logic [31:0] br_target_e,
    input  logic        jal_d,
    input  logic [31:0] jal_target_d,
    output logic [31:0] pc_f,
    output logic        clear_d,
    output logic        misalign,
    output logic [31:0] fetch_count,
    output logic [15:0] redirect_count
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic        pend_ex_q, pend_ex_d;
    logic        misalign_q, misalign_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [15:0] redirect_count_q, redirect_count_d;

    logic        ex_any;
    logic        redir_any;
    logic [31:0] ex_target;
    logic [31:0] sel_target;
    logic [31:0] raw_target;
    logic        advance;
    logic        take;

    // Next-state logic: choose the redirect source, decide whether the PC moves
    // this cycle, manage the pending entry and update the counters.
    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        pend_target_d    = pend_target_q;
        pend_ex_d        = pend_ex_q;
        misalign_d       = misalign_q;
        fetch_count_d    = fetch_count_q;
        redirect_count_d = redirect_count_q;
        clear_d          = 1'b0;
        advance          = 1'b0;
        take             = 1'b0;
        raw_target       = 32'h0;

        ex_any     = jalr_e | br_e;
        redir_any  = ex_any | jal_d;
        ex_target  = jalr_e ? jalr_target_e : br_target_e;
        sel_target = ex_any ? ex_target : jal_target_d;

        unique case (state_q)
            BOOT: begin
                clear_d = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                if (!stall_f) begin
                    advance = 1'b1;
                    if (redir_any) begin
                        take       = 1'b1;
                        raw_target = sel_target;
                        clear_d    = 1'b1;
                    end
                end else if (redir_any) begin
                    pend_target_d = sel_target;
                    pend_ex_d     = ex_any;
                    state_d       = HOLD;
                end
            end
            HOLD: begin
                if (!stall_f) begin
                    advance       = 1'b1;
                    take          = 1'b1;
                    raw_target    = ex_any ? ex_target : pend_target_q;
                    clear_d       = 1'b1;
                    pend_target_d = 32'h0;
                    pend_ex_d     = 1'b0;
                    state_d       = RUN;
                end else if (ex_any) begin
                    pend_target_d = ex_target;
                    pend_ex_d     = 1'b1;
                end else if (jal_d && !pend_ex_q) begin
                    pend_target_d = jal_target_d;
                    pend_ex_d     = 1'b0;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        if (advance) begin
            fetch_count_d = fetch_count_q + 32'd1;
            if (take) begin
                pc_d = {raw_target[31:2], 2'b00};
                if (redirect_count_q != 16'hFFFF) begin
                    redirect_count_d = redirect_count_q + 16'd1;
                end
                if (raw_target[1:0] != 2'b00) begin
                    misalign_d = 1'b1;
                end
            end else begin
                pc_d = pc_q + 32'd4;
            end
        end
    end

    // State registers with asynchronous active-low reset; reset discards any pending redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= BOOT;
            pc_q             <= RESET_PC;
            pend_target_q    <= 32'h0;
            pend_ex_q        <= 1'b0;
            misalign_q       <= 1'b0;
            fetch_count_q    <= 32'h0;
            redirect_count_q <= 16'h0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            pend_target_q    <= pend_target_d;
            pend_ex_q        <= pend_ex_d;
            misalign_q       <= misalign_d;
            fetch_count_q    <= fetch_count_d;
            redirect_count_q <= redirect_count_d;
        end
    end

    assign pc_f           = pc_q;
    assign misalign       = misalign_q;
    assign fetch_count    = fetch_count_q;
    assign redirect_count = redirect_count_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb_if_fetch_ctrl: directed, table-driven bench for the fetch PC sequencer,
// plus hand-written sequences for counter wrap and reset during a held redirect.
module tb_if_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        stall_f;
    logic        jalr_e;
    logic [31:0] jalr_target_e;
    logic        br_e;
    logic [31:0] br_target_e;
    logic        jal_d;
    logic [31:0] jal_target_d;
    logic [31:0] pc_f;
    logic        clear_d;
    logic        misalign;
    logic [31:0] fetch_count;
    logic [15:0] redirect_count;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        stall;
        logic        jalr;
        logic [31:0] jalr_t;
        logic        br;
        logic [31:0] br_t;
        logic        jal;
        logic [31:0] jal_t;
        logic        exp_clear;
        logic [31:0] exp_pc;
        logic [31:0] exp_fc;
        logic [15:0] exp_rc;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[26];

    if_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_f        (stall_f),
        .jalr_e         (jalr_e),
        .jalr_target_e  (jalr_target_e),
        .br_e           (br_e),
        .br_target_e    (br_target_e),
        .jal_d          (jal_d),
        .jal_target_d   (jal_target_d),
        .pc_f           (pc_f),
        .clear_d        (clear_d),
        .misalign       (misalign),
        .fetch_count    (fetch_count),
        .redirect_count (redirect_count)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(
        input logic stall, input logic jalr, input logic [31:0] jalr_t,
        input logic br, input logic [31:0] br_t, input logic jal, input logic [31:0] jal_t,
        input logic exp_clear, input logic [31:0] exp_pc, input logic [31:0] exp_fc,
        input logic [15:0] exp_rc, input logic exp_mis);
        vec_t v;
        v.stall = stall; v.jalr = jalr; v.jalr_t = jalr_t; v.br = br; v.br_t = br_t;
        v.jal = jal; v.jal_t = jal_t; v.exp_clear = exp_clear; v.exp_pc = exp_pc;
        v.exp_fc = exp_fc; v.exp_rc = exp_rc; v.exp_mis = exp_mis;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic stall, input logic jalr, input logic [31:0] jalr_t,
                                  input logic br, input logic [31:0] br_t,
                                  input logic jal, input logic [31:0] jal_t);
        stall_f       = stall;
        jalr_e        = jalr;
        jalr_target_e = jalr_t;
        br_e          = br;
        br_target_e   = br_t;
        jal_d         = jal;
        jal_target_d  = jal_t;
    endtask

    task automatic check_regs(input string tag, input logic [31:0] pc, input logic [31:0] fc,
                              input logic [15:0] rc, input logic mis);
        check_output({tag, "_pc"}, pc_f, pc);
        check_output({tag, "_fc"}, fetch_count, fc);
        check_output({tag, "_rc"}, {16'h0, redirect_count}, {16'h0, rc});
        check_output({tag, "_mis"}, {31'h0, misalign}, {31'h0, mis});
    endtask

    initial begin
        // Expected state after each vector's clock edge, derived by hand.
        //           stall jalr  jalr_t        br    br_t          jal   jal_t         clr  pc            fc     rc     mis
        vecs[0]  = mk(0, 0, 32'h0,        0, 32'h0,     0, 32'h0,   0, 32'h4,         32'd1,  16'd0,  0);
        vecs[1]  = mk(0, 0, 32'h0,        0, 32'h0,     0, 32'h0,   0, 32'h8,         32'd2,  16'd0,  0);
        vecs[2]  = mk(0, 0, 32'h0,        0, 32'h0,     0, 32'h0,   0, 32'hC,         32'd3,  16'd0,  0);
        vecs[3]  = mk(0, 0, 32'h0,        0, 32'h0,     1, 32'h40,  1, 32'h40,        32'd4,  16'd1,  0);
        vecs[4]  = mk(0, 1, 32'h100,      1, 32'h200,   1, 32'h300, 1, 32'h100,       32'd5,  16'd2,  0);
        vecs[5]  = mk(0, 0, 32'h0,        0, 32'h0,     0, 32'h0,   0, 32'h104,       32'd6,  16'd2,  0);
        vecs[6]  = mk(0, 0, 32'h0,        1, 32'h80,    0, 32'h0,   1, 32'h80,        32'd7,  16'd3,  0);
        vecs[7]  = mk(1, 0, 32'h0,        1, 32'h400,   0, 32'h0,   0, 32'h80,        32'd7,  16'd3,  0);
        vecs[8]  = mk(1, 0, 32'h0,        0, 32'h0,     1, 32'h500, 0, 32'h80,        32'd7,  16'd3,  0);
        vecs[9]  = mk(0, 0, 32'h0,        0, 32'h0,     0, 32'h0,   1, 32'h400,       32'd8,  16'd4,  0);
        vecs[10] = mk(1, 0, 32'h0,        0, 32'h0,     0, 32'h0,   0, 32'h400,       32'd8,  16'd4,  0);
        vecs[11] = mk(1, 0, 32'h0,        0, 32'h0,     1, 32'h600, 0, 32'h400,       32'd8,  16'd4,  0);
        vecs[12] = mk(1, 0, 32'h0,        0, 32'h0,     1, 32'h700, 0, 32'h400,       32'd8,  16'd4,  0);
        vecs[13] = mk(1, 0, 32'h0,        1, 32'h800,   0, 32'h0,   0, 32'h400,       32'd8,  16'd4,  0);
        vecs[14] = mk(1, 0, 32'h0,        0, 32'h0,     1, 32'h900, 0, 32'h400,       32'd8,  16'd4,  0);
        vecs[15] = mk(0, 0, 32'h0,        0, 32'h0,     0, 32'h0,   1, 32'h800,       32'd9,  16'd5,  0);
        vecs[16] = mk(1, 0, 32'h0,        0, 32'h0,     1, 32'hA00, 0, 32'h800,       32'd9,  16'd5,  0);
        vecs[17] = mk(0, 0, 32'h0,        1, 32'hB00,   0, 32'h0,   1, 32'hB00,       32'd10, 16'd6,  0);
        vecs[18] = mk(0, 1, 32'hFFFFFFF8, 0, 32'h0,     0, 32'h0,   1, 32'hFFFFFFF8,  32'd11, 16'd7,  0);
        vecs[19] = mk(0, 0, 32'h0,        0, 32'h0,     0, 32'h0,   0, 32'hFFFFFFFC,  32'd12, 16'd7,  0);
        vecs[20] = mk(0, 0, 32'h0,        0, 32'h0,     0, 32'h0,   0, 32'h0,         32'd13, 16'd7,  0);
        vecs[21] = mk(1, 1, 32'h20,       1, 32'h10,    0, 32'h0,   0, 32'h0,         32'd13, 16'd7,  0);
        vecs[22] = mk(0, 0, 32'h0,        0, 32'h0,     1, 32'h30,  1, 32'h20,        32'd14, 16'd8,  0);
        vecs[23] = mk(0, 1, 32'h123,      0, 32'h0,     0, 32'h0,   1, 32'h120,       32'd15, 16'd9,  1);
        vecs[24] = mk(0, 0, 32'h0,        1, 32'h200,   0, 32'h0,   1, 32'h200,       32'd16, 16'd10, 1);
        vecs[25] = mk(0, 0, 32'h0,        0, 32'h0,     0, 32'h0,   0, 32'h204,       32'd17, 16'd10, 1);

        // Reset values before release.
        rst_n = 1'b0;
        apply_stimulus(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        #2;
        check_output("rst_clear", {31'h0, clear_d}, 32'h1);
        check_regs("rst", 32'h0, 32'h0, 16'h0, 1'b0);

        // Release into the boot cycle: PC held, slot cleared.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_output("boot_clear", {31'h0, clear_d}, 32'h1);
        check_output("boot_pc", pc_f, 32'h0);
        @(posedge clk);
        #1;
        check_regs("boot_exit", 32'h0, 32'h0, 16'h0, 1'b0);

        // Table-driven run.
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            apply_stimulus(vecs[i].stall, vecs[i].jalr, vecs[i].jalr_t, vecs[i].br,
                           vecs[i].br_t, vecs[i].jal, vecs[i].jal_t);
            #1;
            check_output($sformatf("v%0d_clear", i), {31'h0, clear_d}, {31'h0, vecs[i].exp_clear});
            @(posedge clk);
            #1;
            check_regs($sformatf("v%0d", i), vecs[i].exp_pc, vecs[i].exp_fc, vecs[i].exp_rc, vecs[i].exp_mis);
        end

        // PC and fetch counter wrap on the same edge; the counter is preloaded by forcing its next value.
        @(negedge clk);
        apply_stimulus(0, 1, 32'hFFFFFFF8, 0, 32'h0, 0, 32'h0);
        @(posedge clk);
        #1;
        check_regs("wrap_a", 32'hFFFFFFF8, 32'd18, 16'd11, 1'b1);
        @(negedge clk);
        apply_stimulus(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        force dut.fetch_count_d = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.fetch_count_d;
        check_regs("wrap_b", 32'hFFFFFFFC, 32'hFFFFFFFF, 16'd11, 1'b1);
        @(posedge clk);
        #1;
        check_regs("wrap_c", 32'h0, 32'h0, 16'd11, 1'b1);
        @(posedge clk);
        #1;
        check_regs("wrap_d", 32'h4, 32'h1, 16'd11, 1'b1);

        // Park a redirect in HOLD, then reset between clock edges.
        @(negedge clk);
        apply_stimulus(1, 0, 32'h0, 1, 32'h1000, 0, 32'h0);
        @(posedge clk);
        #1;
        check_regs("hold", 32'h4, 32'h1, 16'd11, 1'b1);
        @(negedge clk);
        apply_stimulus(1, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async_clear", {31'h0, clear_d}, 32'h1);
        check_regs("async", 32'h0, 32'h0, 16'h0, 1'b0);

        // Redirect offered during boot must be ignored; pending target never appears.
        apply_stimulus(0, 1, 32'h500, 0, 32'h0, 0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_output("boot2_clear", {31'h0, clear_d}, 32'h1);
        @(posedge clk);
        #1;
        check_regs("boot2_exit", 32'h0, 32'h0, 16'h0, 1'b0);
        @(negedge clk);
        apply_stimulus(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        #1;
        check_output("run2_clear", {31'h0, clear_d}, 32'h0);
        @(posedge clk);
        #1;
        check_regs("run2_a", 32'h4, 32'h1, 16'h0, 1'b0);
        @(posedge clk);
        #1;
        check_regs("run2_b", 32'h8, 32'h2, 16'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch_ctrl.md
IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning PC value loaded on reset; bits [1:0] SHALL be zero.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 stall_f  input  1  hazard-unit stall of the fetch stage; 1 = hold PC.
REQ-005 jalr_e  input  1  JALR resolved in EX, redirect requested.
REQ-006 jalr_target_e  input  32  JALR target.
REQ-007 br_e  input  1  taken branch resolved in EX.
REQ-008 br_target_e  input  32  branch target.
REQ-009 jal_d  input  1  JAL decoded in ID.
REQ-010 jal_target_d  input  32  JAL target.
REQ-011 pc_f  output  32  current fetch PC; drives the IF-ID register PC input and instruction-RAM address.
REQ-012 clear_d  output  1  clear request to the IF-ID register for the wrong-path/boot slot.
REQ-013 misalign  output  1  sticky flag: a redirect target had bits [1:0] != 0.
REQ-014 fetch_count  output  32  count of PC advances.
REQ-015 redirect_count  output  16  count of applied redirects, saturating.

Function
REQ-016 States SHALL be BOOT, RUN and HOLD; reset state SHALL be BOOT.
REQ-017 BOOT SHALL last exactly one cycle: pc_f held at RESET_PC, clear_d=1, no redirect accepted, no counter update; then RUN.
REQ-018 Redirect priority in RUN SHALL be jalr_e > br_e > jal_d > sequential (pc_f+4).
REQ-019 Sequential increment SHALL be modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-020 Any selected target SHALL be used with bits [1:0] forced to 0; if the raw bits were nonzero, misalign SHALL set on that edge and stay 1 until reset.
REQ-021 RUN, stall_f=0: pc_f SHALL load the selected next PC on the edge; fetch_count SHALL increment (wrap at 2^32).
REQ-022 RUN, stall_f=0, any redirect present: clear_d SHALL be 1 combinationally in that cycle; redirect_count SHALL increment, saturating at 16'hFFFF.
REQ-023 RUN, stall_f=1, no redirect: pc_f SHALL hold; clear_d=0; no counter change.
REQ-024 RUN, stall_f=1, redirect present: pc_f SHALL hold; the highest-priority target SHALL be latched into a pending register with its level (EX or ID); state -> HOLD; clear_d=0.
REQ-025 HOLD, stall_f=1: a new EX-level redirect SHALL overwrite the pending entry; jal_d SHALL overwrite only an ID-level pending entry; pc_f holds.
REQ-026 HOLD, stall_f=0: pc_f SHALL load the pending target (or a simultaneous EX-level redirect, which takes precedence over pending); clear_d=1; fetch_count and redirect_count SHALL each increment once; state -> RUN.
REQ-027 Only one redirect SHALL be counted per PC update, regardless of how many inputs are asserted.
REQ-028 Latency: a redirect accepted in cycle N SHALL appear on pc_f in cycle N+1.

Reset
REQ-029 On rst_n=0, immediately and independent of clk: pc_f=RESET_PC, state=BOOT, clear_d=1, misalign=0, fetch_count=0, redirect_count=0, pending cleared.
REQ-030 Reset asserted mid-HOLD SHALL discard the pending redirect; after release, the first real fetch SHALL be RESET_PC.

Verification
REQ-031 Release rst_n, stall_f=0, no redirects -> cycle 0 BOOT: pc_f=0, clear_d=1; cycles 1..4: pc_f=0,4,8,12; fetch_count=3 in cycle 4.
REQ-032 RUN at pc_f=0x40, same-cycle jalr_e(0x100), br_e(0x200), jal_d(0x300) -> next pc_f=0x100, clear_d=1 for one cycle, redirect_count+1 only.
REQ-033 pc_f=0x80, stall_f=1 with br_e(0x400) for 1 cycle, jal_d(0x500) next cycle, stall_f=0 in third cycle -> pc_f holds 0x80 for two cycles, then 0x400; clear_d=1 only in the release cycle.
REQ-034 pc_f=0xFFFF_FFFC, no stall/redirect -> pc_f=0x0000_0000; fetch_count 0xFFFF_FFFF -> 0 on the same edge when preloaded by forced sequence.
REQ-035 jalr_e with target 0x0000_0123 -> pc_f=0x0000_0120, misalign=1 and stays 1 through later aligned redirects until rst_n low.
REQ-036 rst_n pulsed low between clock edges during HOLD -> outputs reach reset values without a clk edge; after release BOOT then pc_f=RESET_PC; pending target never appears.
